red_pitaya_asg_trig_seq: RTL and testbench
==========================================

Name: red_pitaya_asg_trig_seq

Overview:
- Per-channel trigger sequencer directly upstream of the double-buffered arbitrary signal generator; drives its per-channel trigger input (trig_a_i / trig_b_i).
- Conditions an asynchronous external trigger pin (synchroniser, glitch filter, edge select) or a software trigger, arms/re-arms, expands each accepted event into a burst of 1-cycle pulses, then enforces a holdoff.
- Two instances per design, one per DAC channel; configuration comes from the ASG register bank.

Parameters:
CW, 32, width of holdoff and burst-period counters
SYNC_STAGES, 2, flip-flop stages on ext_trig_i (minimum 2)

Ports:
dac_clk_i  in  1  DAC clock, 125 MHz
dac_rst_i  in  1  synchronous, active-high reset
cfg_src_i  in  2  0 = disabled, 1 = software, 2 = ext rising, 3 = ext falling
cfg_single_i  in  1  1 = return to IDLE after a sequence; 0 = re-arm automatically
cfg_deb_i  in  16  debounce length in cycles; 0 = no filter
cfg_burst_n_i  in  16  pulses per accepted event; 0 is treated as 1
cfg_burst_per_i  in  CW  cycles between burst pulses; 0 is treated as 1
cfg_holdoff_i  in  CW  dead cycles after the last burst pulse
arm_i  in  1  1-cycle arm request
sw_trig_i  in  1  1-cycle software trigger
abort_i  in  1  1-cycle abort
ext_trig_i  in  1  asynchronous external trigger pin
trig_o  out  1  1-cycle trigger pulse to the ASG
armed_o  out  1  high while in ARMED
busy_o  out  1  high while in BURST or HOLDOFF
trig_cnt_o  out  32  total trig_o pulses, wraps
drop_cnt_o  out  16  events ignored in BURST/HOLDOFF, saturates at 16'hFFFF

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; synchroniser and filter registers 0.
- Synchroniser: ext_trig_i passes through SYNC_STAGES flip-flops to give s.
- Filter: the filtered level f takes the value of s only after s has differed from f for cfg_deb_i consecutive cycles. With cfg_deb_i = 0, f equals s registered once.
- Edge: the event is a rise of f (src 2) or a fall of f (src 3), registered as ev.
- Software event: with src 1, sw_trig_i is the event. Software triggers are ignored for src 2/3, and the external path is ignored for src 1.
- Latency, src 2 with cfg_deb_i = 0: pin edge to trig_o = SYNC_STAGES + 2 cycles.
- Latency, src 1: sw_trig_i in cycle t gives trig_o in cycle t+1.
- Each additional debounce cycle adds 1 cycle of latency.
- FSM transitions:
  - IDLE: arm_i with cfg_src_i != 0 -> ARMED. arm_i with src 0 is ignored.
  - ARMED: an event latches burst_n, burst_per, holdoff and single into shadow registers and moves to BURST. The first trig_o occurs on the cycle of entry into BURST.
  - BURST: pulses are issued every burst_per cycles until burst_n pulses have been sent.
    - After the last pulse, go to HOLDOFF if holdoff > 0.
    - Otherwise go to IDLE if single, else ARMED.
    - Re-arming is effective the cycle after the last pulse.
  - HOLDOFF: runs for holdoff cycles, then goes to IDLE if single, else ARMED.
- Events arriving in BURST/HOLDOFF are dropped and increment drop_cnt_o. Events in IDLE are ignored without counting.
- abort_i in any state: next state IDLE, and no trig_o in the cycle after abort. Abort wins over a simultaneous arm_i or event. Counters are not cleared.
- Simultaneous arm_i and event while in IDLE: the arm is taken and the event is ignored.
- cfg_* changes during BURST/HOLDOFF do not affect the running sequence because the shadow registers are used. cfg_src_i and cfg_deb_i act live.
- trig_cnt_o increments in the cycle trig_o is high and wraps at 2^32.

Decomposition:
- Package red_pitaya_asg_pkg holds:
  - enum trig_src_t {TS_OFF, TS_SW, TS_EXT_RISE, TS_EXT_FALL}
  - enum trig_st_t {ST_IDLE, ST_ARMED, ST_BURST, ST_HOLDOFF}
- Sub-module red_pitaya_trig_cond: synchroniser, debounce filter and edge select. Its output is the 1-cycle event ev.

Test Plan:
- Software single: src = 1, single = 1, burst_n = 1, holdoff = 0; arm, then sw_trig_i at cycle t -> trig_o only at t+1, armed_o returns to 0, trig_cnt_o = 1.
- External rising with debounce: src = 2, deb = 4; pin glitch of 3 cycles -> no trig_o. Clean edge held 10 cycles -> exactly one trig_o, SYNC_STAGES + 6 cycles after the edge.
- Burst: burst_n = 3, burst_per = 5, holdoff = 20, continuous -> trig_o at t, t+5, t+10; busy_o high through t+30. A second event at t+12 -> drop_cnt_o = 1. armed_o = 1 afterwards.
- burst_per = 0, burst_n = 4 -> trig_o high on 4 consecutive cycles, trig_cnt_o = 4.
- Abort mid-burst: burst_n = 10, burst_per = 8; abort_i after the 2nd pulse -> no further trig_o, state IDLE, trig_cnt_o = 2. An event afterwards without arm_i -> no pulse.
- Shadowing and reset: change burst_n from 3 to 1 during BURST -> 3 pulses are still issued. Assert dac_rst_i mid-HOLDOFF -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/red_pitaya_asg_trig_seq_pkg.sv
// Shared types and helpers for the ASG trigger sequencer.
package red_pitaya_asg_pkg;

  typedef enum logic [1:0] {
    TS_OFF      = 2'd0,
    TS_SW       = 2'd1,
    TS_EXT_RISE = 2'd2,
    TS_EXT_FALL = 2'd3
  } trig_src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_BURST   = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_st_t;

  // A programmed count of zero behaves as a count of one.
  function automatic logic [15:0] nz16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_trig_seq_cond.sv
// External trigger conditioning: synchroniser, debounce filter, edge select.
// The event is registered in the same cycle the filtered level changes, so
// with no debounce the pin-to-event path is SYNC_STAGES + 1 cycles.
module red_pitaya_trig_cond
  import red_pitaya_asg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_cfg_src,
  input  logic [15:0] i_cfg_deb,
  input  logic        i_ext_trig,
  output logic        o_ev
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_f;
  logic [15:0]            r_cnt;
  logic                   r_ev;
  logic                   w_s;
  logic                   w_f_nxt;
  logic [15:0]            w_cnt_nxt;
  logic                   w_ev_nxt;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign o_ev = r_ev;

  // Metastability chain on the asynchronous pin.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_trig};
    end
  end

  // Debounce: accept the new level once it has disagreed for cfg_deb cycles.
  always_comb begin
    w_f_nxt   = r_f;
    w_cnt_nxt = r_cnt;
    if (w_s != r_f) begin
      if (r_cnt >= i_cfg_deb) begin
        w_f_nxt   = w_s;
        w_cnt_nxt = 16'd0;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end else begin
      w_cnt_nxt = 16'd0;
    end
  end

  // Edge select on the filtered level according to the live source setting.
  always_comb begin
    case (trig_src_t'(i_cfg_src))
      TS_EXT_RISE: w_ev_nxt = w_f_nxt & ~r_f;
      TS_EXT_FALL: w_ev_nxt = ~w_f_nxt & r_f;
      default:     w_ev_nxt = 1'b0;
    endcase
  end

  // Filter state and registered event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_f   <= 1'b0;
      r_cnt <= 16'd0;
      r_ev  <= 1'b0;
    end else begin
      r_f   <= w_f_nxt;
      r_cnt <= w_cnt_nxt;
      r_ev  <= w_ev_nxt;
    end
  end

endmodule

// File: rtl/red_pitaya_asg_trig_seq.sv
// Per-channel trigger sequencer: arm, burst expansion and holdoff in front
// of the ASG trigger input. Burst settings are shadowed on each accepted event.
module red_pitaya_asg_trig_seq
  import red_pitaya_asg_pkg::*;
#(
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  input  logic [1:0]    cfg_src_i,
  input  logic          cfg_single_i,
  input  logic [15:0]   cfg_deb_i,
  input  logic [15:0]   cfg_burst_n_i,
  input  logic [CW-1:0] cfg_burst_per_i,
  input  logic [CW-1:0] cfg_holdoff_i,
  input  logic          arm_i,
  input  logic          sw_trig_i,
  input  logic          abort_i,
  input  logic          ext_trig_i,
  output logic          trig_o,
  output logic          armed_o,
  output logic          busy_o,
  output logic [31:0]   trig_cnt_o,
  output logic [15:0]   drop_cnt_o
);

  localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  trig_st_t      r_state;
  trig_st_t      w_state_nxt;
  logic          r_trig;
  logic          r_armed;
  logic          r_busy;
  logic [31:0]   r_trig_cnt;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_sh_n;
  logic [CW-1:0] r_sh_per;
  logic [CW-1:0] r_sh_hold;
  logic          r_sh_single;
  logic [15:0]   r_sent;
  logic [CW-1:0] r_per_cnt;
  logic [CW-1:0] r_hold_cnt;

  logic          w_ev_ext;
  logic          w_event;
  logic          w_fire;
  logic          w_latch;
  logic          w_drop;
  logic [15:0]   w_sent_nxt;
  logic [CW-1:0] w_per_nxt;
  logic [CW-1:0] w_hold_nxt;
  logic [CW-1:0] w_per_eff;

  red_pitaya_trig_cond #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cond (
    .i_clk      (dac_clk_i),
    .i_rst      (dac_rst_i),
    .i_cfg_src  (cfg_src_i),
    .i_cfg_deb  (cfg_deb_i),
    .i_ext_trig (ext_trig_i),
    .o_ev       (w_ev_ext)
  );

  assign w_per_eff  = (cfg_burst_per_i == '0) ? ONE_CW : cfg_burst_per_i;
  assign trig_o     = r_trig;
  assign armed_o    = r_armed;
  assign busy_o     = r_busy;
  assign trig_cnt_o = r_trig_cnt;
  assign drop_cnt_o = r_drop_cnt;

  // Pick the event source; the inactive path is ignored.
  always_comb begin
    case (trig_src_t'(cfg_src_i))
      TS_SW:       w_event = sw_trig_i;
      TS_EXT_RISE: w_event = w_ev_ext;
      TS_EXT_FALL: w_event = w_ev_ext;
      default:     w_event = 1'b0;
    endcase
  end

  // Sequencer next-state, pulse generation and counter updates.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_latch     = 1'b0;
    w_drop      = 1'b0;
    w_sent_nxt  = r_sent;
    w_per_nxt   = r_per_cnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (arm_i && (cfg_src_i != 2'd0)) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (w_event) begin
          w_state_nxt = ST_BURST;
          w_fire      = 1'b1;
          w_latch     = 1'b1;
          w_sent_nxt  = 16'd1;
          w_per_nxt   = w_per_eff;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_BURST: begin
        w_drop = w_event;
        // The pulse count is checked in the cycle of the last pulse so the
        // follow-on state starts on the very next cycle.
        if (r_sent >= r_sh_n) begin
          w_hold_nxt = r_sh_hold;
          if (r_sh_hold != '0) begin
            w_state_nxt = ST_HOLDOFF;
          end else if (r_sh_single) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end else if (r_per_cnt <= ONE_CW) begin
          w_fire     = 1'b1;
          w_sent_nxt = r_sent + 16'd1;
          w_per_nxt  = r_sh_per;
        end else begin
          w_per_nxt = r_per_cnt - ONE_CW;
        end
      end
      ST_HOLDOFF: begin
        w_drop = w_event;
        if (r_hold_cnt <= ONE_CW) begin
          w_state_nxt = r_sh_single ? ST_IDLE : ST_ARMED;
        end else begin
          w_hold_nxt = r_hold_cnt - ONE_CW;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Abort overrides everything, including a pulse that would fire now.
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_fire      = 1'b0;
      w_latch     = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, registered outputs, shadows and counters.
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_state     <= ST_IDLE;
      r_trig      <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_trig_cnt  <= 32'd0;
      r_drop_cnt  <= 16'd0;
      r_sh_n      <= 16'd0;
      r_sh_per    <= '0;
      r_sh_hold   <= '0;
      r_sh_single <= 1'b0;
      r_sent      <= 16'd0;
      r_per_cnt   <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_trig     <= w_fire;
      r_armed    <= (w_state_nxt == ST_ARMED);
      r_busy     <= (w_state_nxt == ST_BURST) || (w_state_nxt == ST_HOLDOFF);
      r_sent     <= w_sent_nxt;
      r_per_cnt  <= w_per_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_fire) begin
        r_trig_cnt <= r_trig_cnt + 32'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_latch) begin
        r_sh_n      <= nz16(cfg_burst_n_i);
        r_sh_per    <= w_per_eff;
        r_sh_hold   <= cfg_holdoff_i;
        r_sh_single <= cfg_single_i;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_trig_seq.sv
// Directed bench for the ASG trigger sequencer.
module tb_red_pitaya_asg_trig_seq;

  localparam int CW = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfg_src;
  logic          cfg_single;
  logic [15:0]   cfg_deb;
  logic [15:0]   cfg_n;
  logic [CW-1:0] cfg_per;
  logic [CW-1:0] cfg_hold;
  logic          arm;
  logic          sw;
  logic          abrt;
  logic          ext;
  logic          trig;
  logic          armed;
  logic          busy;
  logic [31:0]   tcnt;
  logic [15:0]   dcnt;

  int n_tests = 0;
  int n_fail  = 0;

  red_pitaya_asg_trig_seq #(.CW(CW), .SYNC_STAGES(SS)) dut (
    .dac_clk_i       (clk),
    .dac_rst_i       (rst),
    .cfg_src_i       (cfg_src),
    .cfg_single_i    (cfg_single),
    .cfg_deb_i       (cfg_deb),
    .cfg_burst_n_i   (cfg_n),
    .cfg_burst_per_i (cfg_per),
    .cfg_holdoff_i   (cfg_hold),
    .arm_i           (arm),
    .sw_trig_i       (sw),
    .abort_i         (abrt),
    .ext_trig_i      (ext),
    .trig_o          (trig),
    .armed_o         (armed),
    .busy_o          (busy),
    .trig_cnt_o      (tcnt),
    .drop_cnt_o      (dcnt)
  );

  always #4 clk = ~clk;

  // Count one comparison and report it when it disagrees.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  initial begin
    logic [31:0] m_trig;
    logic [31:0] m_busy;
    int          hits;
    int          hit_at;
    logic [31:0] base;

    rst = 1'b1; cfg_src = 2'd0; cfg_single = 1'b0; cfg_deb = 16'd0;
    cfg_n = 16'd1; cfg_per = 32'd1; cfg_hold = 32'd0;
    arm = 1'b0; sw = 1'b0; abrt = 1'b0; ext = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_trig",  {31'd0, trig},  32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_tcnt",  tcnt,           32'd0);
    chk("rst_dcnt",  {16'd0, dcnt},  32'd0);

    // Arm with source disabled is ignored.
    do_arm();
    chk("arm_src0", {31'd0, armed}, 32'd0);

    // Software single shot.
    cfg_src = 2'd1; cfg_single = 1'b1; cfg_n = 16'd1; cfg_hold = 32'd0;
    do_arm();
    chk("sw_armed", {31'd0, armed}, 32'd1);
    sw = 1'b1;
    chk("sw_t0_trig", {31'd0, trig}, 32'd0);
    cyc();
    sw = 1'b0;
    chk("sw_t1_trig", {31'd0, trig}, 32'd1);
    chk("sw_t1_tcnt", tcnt, 32'd1);
    cyc();
    chk("sw_t2_trig",  {31'd0, trig},  32'd0);
    chk("sw_t2_armed", {31'd0, armed}, 32'd0);

    // External rising with debounce 4: glitch rejected, clean edge accepted.
    cfg_src = 2'd2; cfg_deb = 16'd4;
    do_arm();
    hits = 0;
    for (int k = 0; k < 15; k++) begin
      ext = (k < 3);
      if (trig) hits++;
      cyc();
    end
    chk("ext_glitch", hits, 32'd0);
    hits = 0; hit_at = -1;
    for (int k = 0; k < 20; k++) begin
      ext = (k < 10);
      if (trig) begin hits++; hit_at = k; end
      cyc();
    end
    chk("ext_hits", hits, 32'd1);
    chk("ext_lat", hit_at, SS + 6);
    for (int k = 0; k < 12; k++) cyc();

    // Continuous burst 3 x 5 with holdoff 20, extra event dropped.
    cfg_src = 2'd1; cfg_deb = 16'd0; cfg_single = 1'b0;
    cfg_n = 16'd3; cfg_per = 32'd5; cfg_hold = 32'd20;
    do_arm();
    m_trig = '0; m_busy = '0;
    for (int k = 0; k < 32; k++) begin
      sw = (k == 0) || (k == 13);
      m_trig[k] = trig;
      m_busy[k] = busy;
      cyc();
    end
    sw = 1'b0;
    chk("bst_trig_mask", m_trig, 32'h0000_0842);
    chk("bst_busy_mask", m_busy, 32'hFFFF_FFFE);
    chk("bst_dcnt",  {16'd0, dcnt},  32'd1);
    chk("bst_armed", {31'd0, armed}, 32'd1);
    chk("bst_busy_end", {31'd0, busy}, 32'd0);
    chk("bst_tcnt",  tcnt, 32'd5);

    // Period 0 behaves as 1: four back-to-back pulses.
    base = tcnt;
    cfg_n = 16'd4; cfg_per = 32'd0; cfg_hold = 32'd0;
    m_trig = '0;
    for (int k = 0; k < 8; k++) begin
      sw = (k == 0);
      m_trig[k] = trig;
      cyc();
    end
    sw = 1'b0;
    chk("p0_trig_mask", m_trig, 32'h0000_001E);
    chk("p0_tcnt_delta", tcnt - base, 32'd4);
    chk("p0_armed", {31'd0, armed}, 32'd1);

    // Abort after the second pulse of a 10 x 8 burst.
    base = tcnt;
    cfg_n = 16'd10; cfg_per = 32'd8;
    m_trig = '0;
    for (int k = 0; k < 32; k++) begin
      sw   = (k == 0);
      abrt = (k == 10);
      m_trig[k] = trig;
      cyc();
    end
    sw = 1'b0; abrt = 1'b0;
    chk("ab_trig_mask", m_trig, 32'h0000_0202);
    chk("ab_tcnt_delta", tcnt - base, 32'd2);
    chk("ab_armed", {31'd0, armed}, 32'd0);
    chk("ab_busy",  {31'd0, busy},  32'd0);
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      sw = (k == 0);
      if (trig) hits++;
      cyc();
    end
    sw = 1'b0;
    chk("ab_idle_ev", hits, 32'd0);
    chk("ab_idle_dcnt", {16'd0, dcnt}, 32'd1);

    // Shadowing: burst_n change mid-burst has no effect; reset mid-holdoff.
    cfg_n = 16'd3; cfg_per = 32'd2; cfg_hold = 32'd20;
    do_arm();
    m_trig = '0;
    for (int k = 0; k < 10; k++) begin
      sw = (k == 0);
      if (k == 2) cfg_n = 16'd1;
      m_trig[k] = trig;
      cyc();
    end
    sw = 1'b0;
    chk("sh_trig_mask", m_trig, 32'h0000_002A);
    chk("sh_busy_hold", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_trig",  {31'd0, trig},  32'd0);
    chk("rst2_armed", {31'd0, armed}, 32'd0);
    chk("rst2_busy",  {31'd0, busy},  32'd0);
    chk("rst2_tcnt",  tcnt,           32'd0);
    chk("rst2_dcnt",  {16'd0, dcnt},  32'd0);
    do_arm();
    chk("rst2_rearm", {31'd0, armed}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
